id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage placed directly downstream of the main control decoder.
//  - Registers the decoded control word and ID operands into EX.
//  - Detects load-use hazards, stalling IF/ID and inserting a bubble.
//  - Squashes the instruction on EX branch/jump redirect.
//  - Runs the STOP (opcode 63) halt-and-drain state machine.
// PARAMETERS
//  DRAIN_CYCLES  3       bubble cycles after STOP before halted (EX, MEM, WB empty)
//  STOP_OPCODE   6'd63   opcode that halts the core
// PORTS
//  clk          in   1   core clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  id_valid     in   1   IF/ID holds a real instruction
//  id_instr     in   32  raw instruction (opcode, rs, rt, rd, shamt, imm16)
//  id_pc4       in   32  PC+4 of the ID instruction
//  id_ctrl      in   18  {RegWriteEN, Mem2RegSEL[1:0], MemWriteEN, Beq, Bne, ALUCtrl[4:0], ALUSrc[4:0], RegDst[1:0]}
//  id_rs_data   in   32  register-file read port A
//  id_rt_data   in   32  register-file read port B
//  ex_flush     in   1   EX resolved a taken branch, jump or jr; ID is wrong-path
//  stall_if     out  1   hold PC and IF/ID this cycle (combinational)
//  ex_valid     out  1   EX holds a real instruction
//  ex_ctrl      out  18  registered control word; zero when bubble
//  ex_rs_data   out  32  registered operand A
//  ex_rt_data   out  32  registered operand B
//  ex_imm16     out  16  instr[15:0]; EX performs the extension
//  ex_shamt     out  5   instr[10:6]
//  ex_rs        out  5   instr[25:21], used by forwarding
//  ex_rt        out  5   instr[20:16]
//  ex_rd        out  5   instr[15:11]
//  ex_pc4       out  32  registered PC+4, used for the JAL link
//  halted       out  1   core stopped; sticky until reset
// BEHAVIOUR
//  - Reset (async, rst_n=0): every registered output is 0, state is RUN, and the drain counter is 0.
//  - Latency: one cycle from ID to EX. With no hazard, all ex_* outputs show the id_* values of the previous edge.
//  - Load-use condition lu: ex_valid, ex_ctrl.Mem2RegSEL==1, ex_rt!=0, and (ex_rt==instr[25:21] or ex_rt==instr[20:16]).
//    Both fields are compared regardless of instruction type (conservative).
//  - Bubble: ex_valid<=0 and ex_ctrl<=0. Data fields may take any value.
//  - Per-cycle priority, highest first:
//    1 ex_flush: load a bubble; stall_if=0; no FSM transition out of RUN.
//    2 lu (RUN only): stall_if=1 and load a bubble. The ID instruction is re-presented next cycle.
//    3 otherwise: capture ID; ex_valid<=id_valid.
//  - FSM:
//    RUN: if id_valid, opcode==STOP_OPCODE, no flush and no lu, load a bubble
//      (STOP never enters EX), set cnt<=DRAIN_CYCLES-1, and go to DRAIN.
//    DRAIN: stall_if=1 and load bubbles.
//      ex_flush -> RUN (STOP was wrong-path); stall_if=0 that cycle.
//      cnt==0 -> HALTED; otherwise cnt--.
//    HALTED: halted=1, stall_if=1, bubbles only; leaves only on reset.
//  - Reset mid-stall or mid-drain: immediate return to RUN, and the bubble state is cleared.
//  - id_valid=0 in RUN: a bubble propagates and the STOP and lu checks are suppressed.
// STRUCTURE
//  - mips_pkg (shared): control-word field offsets and widths (CTRL_W=18),
//    opcode and func constants including STOP, and the state encoding RUN/DRAIN/HALTED.
//  - Sub-module hazard_detect (combinational): inputs ex_valid, ex_ctrl, ex_rt, id rs/rt; output lu.
//  - This module holds the pipeline register, the priority mux and the halt FSM.
// TESTING
//  T1 ADD $3,$1,$2 in ID with ctrl: the next edge gives ex_valid=1, ex_ctrl equal to that ctrl, ex_rd=3, stall_if=0.
//  T2 LW $5,0($1) in EX, then ADD $6,$5,$2 in ID: stall_if=1 for 1 cycle, ex_valid=0,
//     and the ADD enters EX on the following edge.
//  T3 LW $0 in EX, then ADD reading $0: no stall.
//     Same with ex_flush=1 and lu true: bubble, stall_if=0.
//  T4 STOP in ID: EX is a bubble for 3 edges, halted=1 after the 3rd bubble,
//     stall_if stays 1, and later id_valid pulses are ignored.
//  T5 STOP enters DRAIN and ex_flush=1 on the next cycle: back to RUN, halted stays 0, and the fetch resumes.
//  T6 rst_n low in DRAIN, mid-cycle: all outputs are 0 asynchronously and state is RUN after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-word layout, opcode/func constants and
// the ID/EX halt state encoding.
package mips_pkg;

    localparam int CTRL_W = 18;

    // Control word: {RegWriteEN, Mem2RegSEL[1:0], MemWriteEN, Beq, Bne, ALUCtrl[4:0], ALUSrc[4:0], RegDst[1:0]}
    localparam int CTRL_REGDST_LSB  = 0;
    localparam int CTRL_REGDST_W    = 2;
    localparam int CTRL_ALUSRC_LSB  = 2;
    localparam int CTRL_ALUSRC_W    = 5;
    localparam int CTRL_ALUCTRL_LSB = 7;
    localparam int CTRL_ALUCTRL_W   = 5;
    localparam int CTRL_BNE_BIT     = 12;
    localparam int CTRL_BEQ_BIT     = 13;
    localparam int CTRL_MEMWR_BIT   = 14;
    localparam int CTRL_M2R_LSB     = 15;
    localparam int CTRL_M2R_W       = 2;
    localparam int CTRL_REGWR_BIT   = 17;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_STOP  = 6'd63;

    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_JR  = 6'h08;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    function automatic logic [CTRL_M2R_W-1:0] ctrl_mem2reg(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_M2R_LSB +: CTRL_M2R_W];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard check between the load sitting in EX and the instruction in ID.
// Both ID source fields are compared whatever the instruction format.
module hazard_detect
    import mips_pkg::*;
(
    input  logic              ex_valid_i,
    input  logic [CTRL_W-1:0] ex_ctrl_i,
    input  logic [4:0]        ex_rt_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    output logic              lu_o
);

    logic is_load;
    logic unused_ctrl;

    assign is_load     = (ctrl_mem2reg(ex_ctrl_i) == M2R_MEM);
    assign unused_ctrl = ^{ex_ctrl_i[CTRL_W-1:CTRL_M2R_LSB+CTRL_M2R_W], ex_ctrl_i[CTRL_M2R_LSB-1:0]};

    assign lu_o = ex_valid_i && is_load && (ex_rt_i != 5'd0)
                  && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, redirect squash and the
// STOP halt-and-drain state machine.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int         DRAIN_CYCLES = 3,
    parameter logic [5:0] STOP_OPCODE  = OP_STOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic              ex_flush,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [15:0]       ex_imm16,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_pc4,
    output logic              halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    halt_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [25:0]       fields_q;
    logic [31:0]       rs_data_q, rt_data_q, pc4_q;
    logic              lu_raw, lu;
    logic              is_stop;

    hazard_detect u_hazard (
        .ex_valid_i (valid_q),
        .ex_ctrl_i  (ctrl_q),
        .ex_rt_i    (fields_q[20:16]),
        .id_rs_i    (id_instr[25:21]),
        .id_rt_i    (id_instr[20:16]),
        .lu_o       (lu_raw)
    );

    // An empty ID slot can neither stall nor halt the core.
    assign lu      = lu_raw && id_valid;
    assign is_stop = id_valid && (id_instr[31:26] == STOP_OPCODE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_if = 1'b0;
        valid_d  = 1'b0;
        ctrl_d   = '0;
        unique case (state_q)
            ST_RUN: begin
                if (ex_flush) begin
                    // wrong-path ID instruction: squash it
                end else if (lu) begin
                    stall_if = 1'b1;
                end else if (is_stop) begin
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                    state_d = ST_DRAIN;
                end else begin
                    valid_d = id_valid;
                    ctrl_d  = id_valid ? id_ctrl : '0;
                end
            end
            ST_DRAIN: begin
                if (ex_flush) begin
                    state_d = ST_RUN;
                end else begin
                    stall_if = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                stall_if = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            fields_q  <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            pc4_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            // Data fields follow ID every cycle; a bubble is marked by valid/ctrl alone.
            fields_q  <= id_instr[25:0];
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            pc4_q     <= id_pc4;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm16   = fields_q[15:0];
    assign ex_shamt   = fields_q[10:6];
    assign ex_rs      = fields_q[25:21];
    assign ex_rt      = fields_q[20:16];
    assign ex_rd      = fields_q[15:11];
    assign ex_pc4     = pc4_q;
    assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hand-written hazard,
// halt, squash and reset sequences, checked through an expected-result queue.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr, id_pc4, id_rs_data, id_rt_data;
    logic [17:0] id_ctrl;
    logic        ex_flush;
    logic        stall_if, ex_valid, halted;
    logic [17:0] ex_ctrl;
    logic [31:0] ex_rs_data, ex_rt_data, ex_pc4;
    logic [15:0] ex_imm16;
    logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc4     (id_pc4),
        .id_ctrl    (id_ctrl),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .ex_flush   (ex_flush),
        .stall_if   (stall_if),
        .ex_valid   (ex_valid),
        .ex_ctrl    (ex_ctrl),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_imm16   (ex_imm16),
        .ex_shamt   (ex_shamt),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .ex_pc4     (ex_pc4),
        .halted     (halted)
    );

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [17:0] ctrl;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] pc4;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        logic        bub;
        logic        valid;
        logic [17:0] ctrl;
        logic [31:0] instr;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];

    // {RegWr, Mem2Reg[1:0], MemWr, Beq, Bne, ALUCtrl[4:0], ALUSrc[4:0], RegDst[1:0]}
    localparam logic [17:0] C_ADD  = {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd2,  5'd0, 2'd1};
    localparam logic [17:0] C_SUB  = {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd6,  5'd0, 2'd1};
    localparam logic [17:0] C_ORI  = {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd1,  5'd3, 2'd0};
    localparam logic [17:0] C_SW   = {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd2,  5'd1, 2'd0};
    localparam logic [17:0] C_BEQ  = {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 5'd6,  5'd0, 2'd0};
    localparam logic [17:0] C_LW   = {1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 5'd2,  5'd1, 2'd0};
    localparam logic [17:0] C_STOP = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd0, 2'd0};

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] ins, input logic [17:0] c, input logic [31:0] seed);
        vec_t r;
        r.valid     = v;
        r.instr     = ins;
        r.ctrl      = c;
        r.rs_d      = seed ^ 32'hA5A5_0000;
        r.rt_d      = seed ^ 32'h0000_5A5A;
        r.pc4       = 32'h0040_0000 + (seed << 2);
        r.exp_stall = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one ID slot; bub says the stage must turn it into a bubble.
    task automatic drive(input vec_t v, input logic bub);
        exp_t e;
        id_valid   = v.valid;
        id_instr   = v.instr;
        id_ctrl    = v.ctrl;
        id_rs_data = v.rs_d;
        id_rt_data = v.rt_d;
        id_pc4     = v.pc4;
        e.bub   = bub || !v.valid;
        e.valid = v.valid && !bub;
        e.ctrl  = e.valid ? v.ctrl : 18'd0;
        e.instr = v.instr;
        e.rs_d  = v.rs_d;
        e.rt_d  = v.rt_d;
        e.pc4   = v.pc4;
        sb.push_back(e);
        #1;
    endtask

    task automatic step_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            chk("ex_ctrl", {14'd0, ex_ctrl}, {14'd0, e.ctrl});
            if (!e.bub) begin
                chk("ex_rs_data", ex_rs_data, e.rs_d);
                chk("ex_rt_data", ex_rt_data, e.rt_d);
                chk("ex_pc4", ex_pc4, e.pc4);
                chk("ex_imm16", {16'd0, ex_imm16}, {16'd0, e.instr[15:0]});
                chk("ex_shamt", {27'd0, ex_shamt}, {27'd0, e.instr[10:6]});
                chk("ex_rs", {27'd0, ex_rs}, {27'd0, e.instr[25:21]});
                chk("ex_rt", {27'd0, ex_rt}, {27'd0, e.instr[20:16]});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.instr[15:11]});
            end
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        chk(name, {31'd0, stall_if}, {31'd0, exp});
    endtask

    task automatic chk_halt(input string name, input logic exp);
        chk(name, {31'd0, halted}, {31'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t v_lw5, v_use5, v_lw0, v_use0, v_stop, v_add;

        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_ctrl = '0;
        id_rs_data = '0; id_rt_data = '0; id_pc4 = '0; ex_flush = 1'b0;

        tbl[0] = mkv(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), C_ADD, 32'd1);
        tbl[1] = mkv(1'b1, rtype(5'd4, 5'd7, 5'd9, 5'd17, 6'h22), C_SUB, 32'd2);
        tbl[2] = mkv(1'b1, itype(6'd13, 5'd8, 5'd10, 16'hBEEF), C_ORI, 32'd3);
        tbl[3] = mkv(1'b0, rtype(5'd31, 5'd31, 5'd31, 5'd31, 6'h25), C_ADD, 32'd4);
        tbl[4] = mkv(1'b1, itype(6'd43, 5'd29, 5'd11, 16'h8004), C_SW, 32'd5);
        tbl[5] = mkv(1'b1, itype(6'd4, 5'd12, 5'd13, 16'hFFFE), C_BEQ, 32'd6);
        tbl[6] = mkv(1'b1, rtype(5'd30, 5'd0, 5'd21, 5'd5, 6'h00), C_SUB, 32'hFFFF_FFFF);
        tbl[7] = mkv(1'b1, rtype(5'd0, 5'd0, 5'd31, 5'd31, 6'h24), 18'h3FFFF & ~18'h18000, 32'h1234_5678);

        v_lw5  = mkv(1'b1, itype(6'd35, 5'd1, 5'd5, 16'h0000), C_LW, 32'd20);
        v_use5 = mkv(1'b1, rtype(5'd5, 5'd2, 5'd6, 5'd0, 6'h20), C_ADD, 32'd21);
        v_lw0  = mkv(1'b1, itype(6'd35, 5'd1, 5'd0, 16'h0010), C_LW, 32'd22);
        v_use0 = mkv(1'b1, rtype(5'd0, 5'd0, 5'd7, 5'd0, 6'h20), C_ADD, 32'd23);
        v_stop = mkv(1'b1, {6'd63, 26'h0ABCDEF}, C_STOP, 32'd30);
        v_add  = mkv(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), C_ADD, 32'd31);

        // Reset state
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_ctrl", {14'd0, ex_ctrl}, 32'd0);
        chk("rst_ex_rs_data", ex_rs_data, 32'd0);
        chk("rst_ex_pc4", ex_pc4, 32'd0);
        chk_halt("rst_halted", 1'b0);
        chk_stall("rst_stall_if", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // T1 and plain capture patterns
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i], 1'b0);
            chk_stall("tbl_stall_if", tbl[i].exp_stall);
            step_check();
        end

        // T2: load-use stall, then the held instruction enters EX
        drive(v_lw5, 1'b0);
        step_check();
        drive(v_use5, 1'b1);
        chk_stall("t2_stall_if_lu", 1'b1);
        step_check();
        drive(v_use5, 1'b0);
        chk_stall("t2_stall_if_release", 1'b0);
        step_check();

        // An empty ID slot whose fields match the load does not stall
        drive(v_lw5, 1'b0);
        step_check();
        v_use5.valid = 1'b0;
        drive(v_use5, 1'b1);
        chk_stall("lu_suppressed_invalid", 1'b0);
        step_check();
        v_use5.valid = 1'b1;

        // T3: load to $0 never stalls; flush beats load-use
        drive(v_lw0, 1'b0);
        step_check();
        drive(v_use0, 1'b0);
        chk_stall("t3_stall_if_r0", 1'b0);
        step_check();
        drive(v_lw5, 1'b0);
        step_check();
        ex_flush = 1'b1;
        drive(v_use5, 1'b1);
        chk_stall("t3_stall_if_flush", 1'b0);
        step_check();
        ex_flush = 1'b0;

        // T4: STOP drains EX for DRAIN_CYCLES edges, then halts
        drive(v_stop, 1'b1);
        step_check();
        chk_stall("t4_stall_drain", 1'b1);
        chk_halt("t4_halted_e1", 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(v_add, 1'b1);
            step_check();
            chk_halt("t4_halted_drain", (i == 2) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            v_add.valid = i[0];
            ex_flush = (i == 1);
            drive(v_add, 1'b1);
            chk_stall("t4_stall_halted", 1'b1);
            step_check();
            chk_halt("t4_halted_sticky", 1'b1);
        end
        v_add.valid = 1'b1;
        ex_flush = 1'b0;
        do_reset();
        chk_halt("t4_halted_cleared", 1'b0);

        // T5: STOP squashed by a redirect while draining
        drive(v_stop, 1'b1);
        step_check();
        chk_stall("t5_stall_drain", 1'b1);
        ex_flush = 1'b1;
        drive(v_add, 1'b1);
        chk_stall("t5_stall_flush", 1'b0);
        step_check();
        ex_flush = 1'b0;
        chk_stall("t5_stall_run", 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i], 1'b0);
            step_check();
            chk_halt("t5_halted", 1'b0);
        end

        // T6: asynchronous reset in the middle of a drain
        drive(v_add, 1'b0);
        step_check();
        drive(v_stop, 1'b1);
        step_check();
        chk_stall("t6_stall_drain", 1'b1);
        id_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("t6_ex_rs_data", ex_rs_data, 32'd0);
        chk("t6_ex_rt_data", ex_rt_data, 32'd0);
        chk("t6_ex_pc4", ex_pc4, 32'd0);
        chk("t6_ex_imm16", {16'd0, ex_imm16}, 32'd0);
        chk_stall("t6_stall_if", 1'b0);
        chk_halt("t6_halted", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        drive(v_add, 1'b0);
        chk_stall("t6_stall_after", 1'b0);
        step_check();
        for (int i = 0; i < 4; i++) begin
            drive(v_add, 1'b0);
            step_check();
            chk_halt("t6_run_after", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
